sram_bridge: RTL and testbench

- Memory-side stage directly downstream of the 68k bus switch.
- Accepts one 32-bit request on the mem* handshake. The request carries a 16-bit value plus its bitwise complement.
- Executes the request as two 16-bit accesses to an external asynchronous SRAM.
- Returns the 32-bit word with a one-cycle ack and checks complement integrity on reads.

---
 rtl/sram_bridge_if.sv | 22 ++
 rtl/sram_bridge.sv | 151 +++++++++++++++
 tb/tb_sram_bridge.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bridge_if.sv
// rtl/sram_bridge_if.sv - request/ack handshake between the 68k bus switch and sram_bridge
// Purpose : bundles the mem* request/response signals of the memory stage.
// Signals : memreq   - request strobe (may be a 1-cycle pulse)
//           memaddr  - 20-bit word address, sampled with memreq
//           memwdata - 32-bit write word {hi, lo}, sampled with memreq
//           memwr    - 1 = write, 0 = read, sampled with memreq
//           memack   - 1-cycle completion pulse
//           memrdata - 32-bit read word {hi, lo}, valid while memack=1
// Modports: master = bus switch side, slave = bridge side.
interface sram_bridge_if;
   logic        memreq;
   logic [19:0] memaddr;
   logic [31:0] memwdata;
   logic        memwr;
   logic        memack;
   logic [31:0] memrdata;

   modport master (output memreq, memaddr, memwdata, memwr,
                   input  memack, memrdata);
   modport slave  (input  memreq, memaddr, memwdata, memwr,
                   output memack, memrdata);
endinterface

// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - 32-bit request to two 16-bit asynchronous SRAM accesses with complement check
// Purpose : executes one 32-bit request as a low then a high halfword access
//           to an external asynchronous SRAM; on reads checks hi == ~lo.
// Ports   : clk, rstn          - clock, synchronous active-low reset
//           mem (slave)        - memreq/memaddr/memwdata/memwr/memack/memrdata
//           sram_a             - halfword address {addr, half}
//           sram_dq_o/_i/_oe   - data bus out, in, drive enable
//           sram_ce_n/we_n/oe_n- active-low SRAM strobes
//           err                - integrity failure pulse, coincident with memack
//           errcnt             - saturating integrity failure count
// Params  : WAIT - strobe cycles per halfword (1..15), ERRW - errcnt width.
module sram_bridge #(
   parameter int WAIT = 2,
   parameter int ERRW = 8
) (
   input  logic            clk,
   input  logic            rstn,
   sram_bridge_if.slave    mem,
   output logic [20:0]     sram_a,
   output logic [15:0]     sram_dq_o,
   input  logic [15:0]     sram_dq_i,
   output logic            sram_dq_oe,
   output logic            sram_ce_n,
   output logic            sram_we_n,
   output logic            sram_oe_n,
   output logic            err,
   output logic [ERRW-1:0] errcnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_LO_SETUP, S_LO_STROBE, S_HI_SETUP, S_HI_STROBE, S_ACK
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(WAIT - 1);

   state_t          r_state;
   logic [3:0]      r_wcnt;
   logic [19:0]     r_addr;
   logic [31:0]     r_wdata;
   logic            r_wr;
   logic [15:0]     r_lo;
   logic            r_memack;
   logic [31:0]     r_memrdata;
   logic            r_err;
   logic [ERRW-1:0] r_errcnt;
   logic [20:0]     r_sram_a;
   logic [15:0]     r_dq_o;
   logic            r_dq_oe;
   logic            r_ce_n;
   logic            r_we_n;
   logic            r_oe_n;

   // hi half arrives on sram_dq_i in the last HI strobe cycle; lo is already held
   logic w_bad;
   assign w_bad = (sram_dq_i != ~r_lo);

   // Outputs are registered: each transition loads the values of the state being entered.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state    <= S_IDLE;
         r_wcnt     <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wr       <= 1'b0;
         r_lo       <= '0;
         r_memack   <= 1'b0;
         r_memrdata <= '0;
         r_err      <= 1'b0;
         r_errcnt   <= '0;
         r_sram_a   <= '0;
         r_dq_o     <= '0;
         r_dq_oe    <= 1'b0;
         r_ce_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_oe_n     <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mem.memreq) begin
                  r_addr   <= mem.memaddr;
                  r_wdata  <= mem.memwdata;
                  r_wr     <= mem.memwr;
                  r_sram_a <= {mem.memaddr, 1'b0};
                  r_dq_o   <= mem.memwdata[15:0];
                  r_dq_oe  <= mem.memwr;
                  r_ce_n   <= 1'b0;
                  r_we_n   <= 1'b1;
                  r_oe_n   <= mem.memwr;
                  r_state  <= S_LO_SETUP;
               end
            end
            S_LO_SETUP: begin
               r_wcnt  <= WAIT_LAST;
               r_we_n  <= ~r_wr;
               r_state <= S_LO_STROBE;
            end
            S_LO_STROBE: begin
               if (r_wcnt == 4'd0) begin
                  r_lo     <= sram_dq_i;
                  // we_n rises together with the address change, never after it
                  r_we_n   <= 1'b1;
                  r_sram_a <= {r_addr, 1'b1};
                  r_dq_o   <= r_wdata[31:16];
                  r_state  <= S_HI_SETUP;
               end else begin
                  r_wcnt <= r_wcnt - 4'd1;
               end
            end
            S_HI_SETUP: begin
               r_wcnt  <= WAIT_LAST;
               r_we_n  <= ~r_wr;
               r_state <= S_HI_STROBE;
            end
            S_HI_STROBE: begin
               if (r_wcnt == 4'd0) begin
                  r_memack   <= 1'b1;
                  r_memrdata <= r_wr ? r_wdata : {sram_dq_i, r_lo};
                  r_err      <= ~r_wr & w_bad;
                  if (!r_wr && w_bad && r_errcnt != '1)
                     r_errcnt <= r_errcnt + 1'b1;
                  r_ce_n     <= 1'b1;
                  r_we_n     <= 1'b1;
                  r_oe_n     <= 1'b1;
                  r_dq_oe    <= 1'b0;
                  r_state    <= S_ACK;
               end else begin
                  r_wcnt <= r_wcnt - 4'd1;
               end
            end
            S_ACK: begin
               r_memack <= 1'b0;
               r_err    <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem.memack   = r_memack;
   assign mem.memrdata = r_memrdata;
   assign sram_a       = r_sram_a;
   assign sram_dq_o    = r_dq_o;
   assign sram_dq_oe   = r_dq_oe;
   assign sram_ce_n    = r_ce_n;
   assign sram_we_n    = r_we_n;
   assign sram_oe_n    = r_oe_n;
   assign err          = r_err;
   assign errcnt       = r_errcnt;

endmodule

// File: tb/tb_sram_bridge.sv
// tb/tb_sram_bridge.sv - randomized self-checking bench for sram_bridge (WAIT=2 and WAIT=1 instances)
module tb_sram_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn;
   logic        req   [2];
   logic [19:0] addr  [2];
   logic [31:0] wdata [2];
   logic        wr    [2];
   logic        ack   [2];
   logic [31:0] rdata [2];
   logic [20:0] sa    [2];
   logic [15:0] dq_o  [2];
   logic [15:0] dq_i  [2];
   logic        dq_oe [2];
   logic        ce_n  [2];
   logic        we_n  [2];
   logic        oe_n  [2];
   logic        err   [2];
   logic [7:0]  errcnt[2];

   sram_bridge_if mif0 ();
   sram_bridge_if mif1 ();

   assign mif0.memreq   = req[0];
   assign mif0.memaddr  = addr[0];
   assign mif0.memwdata = wdata[0];
   assign mif0.memwr    = wr[0];
   assign ack[0]        = mif0.memack;
   assign rdata[0]      = mif0.memrdata;
   assign mif1.memreq   = req[1];
   assign mif1.memaddr  = addr[1];
   assign mif1.memwdata = wdata[1];
   assign mif1.memwr    = wr[1];
   assign ack[1]        = mif1.memack;
   assign rdata[1]      = mif1.memrdata;

   sram_bridge #(.WAIT(2), .ERRW(8)) u_dut0 (
      .clk(clk), .rstn(rstn), .mem(mif0),
      .sram_a(sa[0]), .sram_dq_o(dq_o[0]), .sram_dq_i(dq_i[0]), .sram_dq_oe(dq_oe[0]),
      .sram_ce_n(ce_n[0]), .sram_we_n(we_n[0]), .sram_oe_n(oe_n[0]),
      .err(err[0]), .errcnt(errcnt[0]));

   sram_bridge #(.WAIT(1), .ERRW(8)) u_dut1 (
      .clk(clk), .rstn(rstn), .mem(mif1),
      .sram_a(sa[1]), .sram_dq_o(dq_o[1]), .sram_dq_i(dq_i[1]), .sram_dq_oe(dq_oe[1]),
      .sram_ce_n(ce_n[1]), .sram_we_n(we_n[1]), .sram_oe_n(oe_n[1]),
      .err(err[1]), .errcnt(errcnt[1]));

   // asynchronous SRAM devices (halfword storage) plus strobe monitors
   logic [15:0] mem0 [bit [20:0]];
   logic [15:0] mem1 [bit [20:0]];
   int          wlow [2];
   int          viol [2];
   bit          prev_we_low [2];
   logic [20:0] prev_sa [2];

   always @(negedge clk) begin
      if (!ce_n[0] && !we_n[0] && dq_oe[0]) mem0[sa[0]] = dq_o[0];
      if (!ce_n[1] && !we_n[1] && dq_oe[1]) mem1[sa[1]] = dq_o[1];
      dq_i[0] = (!ce_n[0] && !oe_n[0] && mem0.exists(sa[0])) ? mem0[sa[0]] : 16'h0000;
      dq_i[1] = (!ce_n[1] && !oe_n[1] && mem1.exists(sa[1])) ? mem1[sa[1]] : 16'h0000;
      for (int s = 0; s < 2; s++) begin
         if (!we_n[s]) begin
            wlow[s]++;
            if (prev_we_low[s] && sa[s] != prev_sa[s]) viol[s]++;
         end
         prev_we_low[s] = !we_n[s];
         prev_sa[s]     = sa[s];
      end
   end

   // reference model: 32-bit word per address, saturating error counts
   logic [31:0] ref0 [bit [19:0]];
   logic [31:0] ref1 [bit [19:0]];
   int          exp_cnt [2];
   int          n_vec = 0;
   int          n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_get(input int sel, input logic [19:0] a);
      if (sel == 0) return ref0.exists(a) ? ref0[a] : 32'h0;
      return ref1.exists(a) ? ref1[a] : 32'h0;
   endfunction

   function automatic logic [15:0] mem_get(input int sel, input logic [20:0] a);
      if (sel == 0) return mem0.exists(a) ? mem0[a] : 16'h0;
      return mem1.exists(a) ? mem1[a] : 16'h0;
   endfunction

   task automatic do_req(input int sel, input logic [19:0] a, input logic [31:0] d,
                         input bit w, input bit repulse);
      int          n, wl0, lat, stray, extra;
      bit          got;
      logic [31:0] exp_rd;
      bit          exp_err;
      lat = (sel == 0) ? 2 * 2 + 3 : 2 * 1 + 3;
      if (w) begin
         exp_rd  = d;
         exp_err = 1'b0;
      end else begin
         exp_rd  = ref_get(sel, a);
         exp_err = (exp_rd[31:16] != ~exp_rd[15:0]);
      end
      @(negedge clk);
      wl0 = wlow[sel];
      req[sel] = 1'b1; addr[sel] = a; wdata[sel] = d; wr[sel] = w;
      n = 0; got = 0; stray = 0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            addr[sel] = 20'($urandom); wdata[sel] = $urandom; wr[sel] = 1'($urandom);
         end
         req[sel] = repulse && (n == 3 || n == 7);
         if (ack[sel]) got = 1;
         else if (err[sel]) stray++;
      end
      if (!got) begin
         check("ack_timeout", 32'd0, 32'd1);
      end else begin
         if (exp_err && exp_cnt[sel] < 255) exp_cnt[sel]++;
         if (w) begin
            if (sel == 0) ref0[a] = d; else ref1[a] = d;
         end
         check("latency",  n, lat);
         check("rdata",    rdata[sel], exp_rd);
         check("err",      32'(err[sel]), 32'(exp_err));
         check("errcnt",   32'(errcnt[sel]), exp_cnt[sel]);
         check("ce_n_ack", 32'(ce_n[sel]), 32'd1);
         check("we_low",   wlow[sel] - wl0, w ? 2 * (lat - 3) / 2 : 0);
         check("err_stray", stray, 0);
      end
      if (repulse) begin
         extra = 0;
         @(negedge clk);
         req[sel] = 1'b0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack[sel]) extra++;
         end
         check("single_ack", extra, 0);
      end
   endtask

   task automatic rand_ops(input int sel, input int count);
      logic [19:0] a;
      logic [15:0] lo;
      logic [31:0] d;
      bit          w;
      for (int i = 0; i < count; i++) begin
         a  = 20'h40000 + 20'($urandom_range(0, 7));
         w  = 1'($urandom);
         lo = 16'($urandom);
         d  = $urandom_range(0, 1) ? {~lo, lo} : $urandom;
         do_req(sel, a, d, w, 1'b0);
      end
   endtask

   initial begin
      int n, acks;
      rstn = 1'b0;
      for (int s = 0; s < 2; s++) begin
         req[s] = 0; addr[s] = 0; wdata[s] = 0; wr[s] = 0; exp_cnt[s] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_memack", 32'(ack[0]), 0);
      check("rst_rdata",  rdata[0], 0);
      check("rst_err",    32'(err[0]), 0);
      check("rst_errcnt", 32'(errcnt[0]), 0);
      check("rst_sram_a", 32'(sa[0]), 0);
      check("rst_dq_o",   32'(dq_o[0]), 0);
      check("rst_dq_oe",  32'(dq_oe[0]), 0);
      check("rst_ce_n",   32'(ce_n[0]), 1);
      check("rst_we_n",   32'(we_n[0]), 1);
      check("rst_oe_n",   32'(oe_n[0]), 1);
      rstn = 1'b1;

      // directed write / read / corrupted read
      do_req(0, 20'h80010, 32'hEDCB1234, 1'b1, 1'b0);
      check("sram_lo", 32'(mem_get(0, 21'h100020)), 32'h1234);
      check("sram_hi", 32'(mem_get(0, 21'h100021)), 32'hEDCB);
      do_req(0, 20'h80010, 32'h0, 1'b0, 1'b0);
      do_req(0, 20'h80010, 32'h00001234, 1'b1, 1'b0);
      do_req(0, 20'h80010, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) do_req(0, 20'h80010, 32'h0, 1'b0, 1'b0);
      check("errcnt_sat", 32'(errcnt[0]), 32'hFF);

      // WAIT=1 back-to-back random traffic
      rand_ops(1, 30);

      // re-pulsed memreq during an active request
      do_req(0, 20'h40001, 32'h5A5AA5A5, 1'b1, 1'b1);
      do_req(0, 20'h40001, 32'h0, 1'b0, 1'b1);

      // reset in cycle 4 of a write
      @(negedge clk);
      req[0] = 1'b1; addr[0] = 20'h12345; wdata[0] = 32'hABCD5678; wr[0] = 1'b1;
      n = 0;
      while (n < 4) begin
         @(negedge clk);
         n++;
         req[0] = 1'b0;
      end
      rstn = 1'b0;
      @(negedge clk);
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      check("abort_ce_n",   32'(ce_n[0]), 1);
      check("abort_we_n",   32'(we_n[0]), 1);
      check("abort_oe_n",   32'(oe_n[0]), 1);
      check("abort_dq_oe",  32'(dq_oe[0]), 0);
      check("abort_sram_a", 32'(sa[0]), 0);
      check("abort_errcnt", 32'(errcnt[0]), 0);
      rstn = 1'b1;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (ack[0]) acks++;
      end
      check("abort_no_ack", acks, 0);
      check("abort_hi_unwritten", 32'(mem0.exists(21'h2468B)), 0);
      check("abort_lo_written", 32'(mem_get(0, 21'h2468A)), 32'h5678);
      ref0[20'h12345] = 32'h00005678;
      do_req(0, 20'h12345, 32'h0, 1'b0, 1'b0);

      // reset and memreq in the same cycle
      @(negedge clk);
      rstn = 1'b0; req[0] = 1'b1; addr[0] = 20'h23456; wdata[0] = 32'h11112222; wr[0] = 1'b1;
      @(negedge clk);
      rstn = 1'b1; req[0] = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      acks = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (ack[0]) acks++;
      end
      check("rstreq_no_ack", acks, 0);
      check("rstreq_unwritten", 32'(mem0.exists(21'h468AC)), 0);

      // random traffic on the WAIT=2 instance
      rand_ops(0, 30);
      check("we_addr_stable0", viol[0], 0);
      check("we_addr_stable1", viol[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
